shift_sequencer: RTL and testbench

Multi-cycle controller that sequences a fixed-stride logical shift datapath to perform variable-amount left or right shifts of an N-bit unsigned operand. Each cycle it shifts by at most STEP bit positions, which bounds the shifter's logic depth. It sits between a valid/ready producer and a valid/ready consumer, holds one operation in flight, and exposes a busy flag to the surrounding pipeline control.

---
 rtl/shift_sequencer.sv | 134 +++++++++++++
 tb/tb_shift_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle logical shifter controller.
// An accepted operand is shifted by at most STEP bit positions per cycle
// until the clamped amount is used up. The result is then held until the
// consumer takes it. in_ready, out_valid and busy are registered flags that
// change together with the state, so no input reaches an output through
// combinational logic.
module shift_sequencer #(
  parameter int N    = 8,
  parameter int STEP = 1,
  parameter int AW   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [AW-1:0] in_amt,
  input  logic          in_dir,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          busy
);

  localparam logic [AW-1:0] N_AMT    = AW'(N);
  localparam logic [AW-1:0] STEP_AMT = AW'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t        state_q;
  logic [N-1:0]  data_q;
  logic [AW-1:0] rem_q;
  logic          dir_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;

  logic [AW-1:0] amt_clamp_d;
  logic [AW-1:0] step_d;
  logic [AW-1:0] rem_d;
  logic [N-1:0]  data_d;

  // Clamp the requested amount to N; any larger amount also yields zero.
  always_comb begin
    amt_clamp_d = in_amt;
    if (in_amt > N_AMT) begin
      amt_clamp_d = N_AMT;
    end else begin
      amt_clamp_d = in_amt;
    end
  end

  // One bounded shift step: distance is min(rem, STEP), vacated bits are zero.
  always_comb begin
    step_d = rem_q;
    data_d = data_q;
    if (rem_q > STEP_AMT) begin
      step_d = STEP_AMT;
    end else begin
      step_d = rem_q;
    end
    if (dir_q) begin
      data_d = data_q << step_d;
    end else begin
      data_d = data_q >> step_d;
    end
    rem_d = rem_q - step_d;
  end

  // Sequencer FSM: state, datapath registers and registered handshake flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= {N{1'b0}};
      rem_q       <= {AW{1'b0}};
      dir_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q     <= in_data;
            dir_q      <= in_dir;
            rem_q      <= amt_clamp_d;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (amt_clamp_d == {AW{1'b0}}) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q     <= SHIFT;
              out_valid_q <= 1'b0;
            end
          end
        end
        SHIFT: begin
          data_q <= data_d;
          rem_q  <= rem_d;
          if (rem_d == {AW{1'b0}}) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          rem_q       <= {AW{1'b0}};
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: two instances (STEP=1 and STEP=3, N=8) driven
// by directed vectors and a random run, checked every cycle against a
// cycle-counting transaction model plus hand-computed literal expectations.
module tb_shift_sequencer;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid [2];
  logic       in_ready [2];
  logic [7:0] in_data  [2];
  logic [3:0] in_amt   [2];
  logic       in_dir   [2];
  logic       out_valid[2];
  logic       out_ready[2];
  logic [7:0] out_data [2];
  logic       busy     [2];

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    shift_sequencer #(.N(8), .STEP(g == 0 ? 1 : 3), .AW(4)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .in_amt   (in_amt[g]),
      .in_dir   (in_dir[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g]),
      .busy     (busy[g])
    );
  end

  function automatic int step_of(int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] ref_shift(logic [7:0] a, int amt, bit dir);
    logic [7:0] r;
    if (amt >= N) r = 8'h00;
    else if (dir) r = a << amt;
    else r = a >> amt;
    return r;
  endfunction

  function automatic int ref_lat(int amt, int s);
    int r;
    r = (amt < N) ? amt : N;
    return 1 + (r + s - 1) / s;
  endfunction

  task automatic chk(string name, int g, logic [31:0] act, logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, g, act, exp, $time);
    end
  endtask

  // Transaction model: per instance, whether an operation is held, edges
  // since its accept, the latency at which it must finish, and its result.
  bit         armed = 1'b0;
  bit         m_busy[2];
  int         m_cnt [2];
  int         m_lat [2];
  logic [7:0] m_res [2];

  always @(posedge clk) begin
    if (!rst_n) armed = 1'b1;
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        m_busy[g] = 1'b0;
        m_cnt[g]  = 0;
        m_lat[g]  = 0;
        m_res[g]  = 8'h00;
      end else if (!m_busy[g]) begin
        if (in_valid[g] === 1'b1) begin
          m_busy[g] = 1'b1;
          m_cnt[g]  = 1;
          m_lat[g]  = ref_lat(int'(in_amt[g]), step_of(g));
          m_res[g]  = ref_shift(in_data[g], int'(in_amt[g]), in_dir[g]);
        end
      end else if (m_cnt[g] >= m_lat[g]) begin
        if (out_ready[g] === 1'b1) m_busy[g] = 1'b0;
      end else begin
        m_cnt[g] = m_cnt[g] + 1;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (armed) begin
      for (int g = 0; g < 2; g++) begin
        bit ev;
        ev = m_busy[g] && (m_cnt[g] >= m_lat[g]);
        chk("cyc_in_ready", g, 32'(in_ready[g]), 32'(!m_busy[g]));
        chk("cyc_busy", g, 32'(busy[g]), 32'(m_busy[g]));
        chk("cyc_out_valid", g, 32'(out_valid[g]), 32'(ev));
        if (!m_busy[g] || ev) chk("cyc_out_data", g, 32'(out_data[g]), 32'(m_res[g]));
      end
    end
  end

  task automatic start_op(int g, logic [7:0] d, logic [3:0] a, logic dir);
    @(negedge clk);
    in_valid[g] = 1'b1;
    in_data[g]  = d;
    in_amt[g]   = a;
    in_dir[g]   = dir;
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
    in_data[g]  = ~d;
    in_amt[g]   = ~a;
    in_dir[g]   = ~dir;
  endtask

  task automatic wait_valid(int g, logic [7:0] exp_d, int exp_lat);
    int k;
    bit seen;
    seen = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid[g] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("latency", g, 32'(k), 32'(exp_lat));
    if (seen) chk("result", g, 32'(out_data[g]), 32'(exp_d));
  endtask

  task automatic finish_op(int g, int stall);
    repeat (stall) @(negedge clk);
    out_ready[g] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[g] = 1'b0;
  endtask

  task automatic run_op(int g, logic [7:0] d, logic [3:0] a, logic dir,
                        logic [7:0] exp_d, int exp_lat, int stall);
    start_op(g, d, a, dir);
    wait_valid(g, exp_d, exp_lat);
    finish_op(g, stall);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      in_valid[g]  = 1'b0;
      in_data[g]   = 8'h00;
      in_amt[g]    = 4'h0;
      in_dir[g]    = 1'b0;
      out_ready[g] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_out_valid", g, 32'(out_valid[g]), 32'h0);
      chk("rst_out_data", g, 32'(out_data[g]), 32'h0);
      chk("rst_busy", g, 32'(busy[g]), 32'h0);
      chk("rst_in_ready", g, 32'(in_ready[g]), 32'h1);
    end
    rst_n = 1'b1;

    // Directed vectors with hand-computed results and latencies.
    run_op(0, 8'hB4, 4'd3, 1'b0, 8'h16, 4, 0);
    run_op(0, 8'hB4, 4'd3, 1'b1, 8'hA0, 4, 1);
    run_op(1, 8'hFF, 4'd7, 1'b0, 8'h01, 4, 0);
    run_op(0, 8'hB4, 4'd0, 1'b0, 8'hB4, 1, 0);
    run_op(0, 8'hB4, 4'd9, 1'b1, 8'h00, 9, 0);
    run_op(1, 8'hB4, 4'd8, 1'b0, 8'h00, 4, 2);

    // Backpressure with a second operation offered throughout the stall.
    start_op(0, 8'h3C, 4'd2, 1'b0);
    wait_valid(0, 8'h0F, 3);
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h81;
    in_amt[0]   = 4'd1;
    in_dir[0]   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 0, 32'(in_ready[0]), 32'h0);
      chk("bp_busy", 0, 32'(busy[0]), 32'h1);
      chk("bp_out_data", 0, 32'(out_data[0]), 32'h0F);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    @(negedge clk);
    chk("bp_idle_in_ready", 0, 32'(in_ready[0]), 32'h1);
    chk("bp_idle_out_valid", 0, 32'(out_valid[0]), 32'h0);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    wait_valid(0, 8'h02, 2);
    finish_op(0, 0);

    // Reset in the middle of a SHIFT phase, then a normal operation.
    start_op(0, 8'hC3, 4'd6, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 0, 32'(out_valid[0]), 32'h0);
    chk("mid_rst_out_data", 0, 32'(out_data[0]), 32'h0);
    chk("mid_rst_busy", 0, 32'(busy[0]), 32'h0);
    chk("mid_rst_in_ready", 0, 32'(in_ready[0]), 32'h1);
    rst_n = 1'b1;
    run_op(0, 8'h0F, 4'd2, 1'b1, 8'h3C, 3, 0);

    // Random operations with random consumer stalls.
    for (int i = 0; i < 1000; i++) begin
      int         g;
      logic [7:0] d;
      logic [3:0] a;
      logic       dir;
      g   = int'($urandom_range(0, 1));
      d   = 8'($urandom);
      a   = 4'($urandom_range(0, 15));
      dir = 1'($urandom_range(0, 1));
      run_op(g, d, a, dir, ref_shift(d, int'(a), dir),
             ref_lat(int'(a), step_of(g)), int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
